// File: rtl/pac.sv
// pac -- packet action controller.
// Buffers each incoming packet together with its 11-bit action in a store-and-forward
// buffer, commits or discards it on the tail valid strobe, and dispatches committed
// packets in arrival order to port 0/1/2 (unicast) or to all three (broadcast).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_pac_data[133:0]           [133:132] 01 head / 11 mid / 10 tail, [131:128] bytes-1, [127:0] payload
//   in_pac_data_wr               word strobe, one word per cycle, no backpressure
//   in_pac_valid, _valid_wr      commit(1)/discard(0) and its strobe, aligned with the tail
//   in_pac_action[10:0], _wr     [10:9] 00 unicast / 10 broadcast, [5:0] port; aligned with head
//   out_portN_data/_data_wr      packet word and strobe to port N
//   in_portN_alf                 port N almost-full, checked only before a packet starts
//   out_pac_pkt_cnt/_drop_cnt    dispatched / dropped packet counters (wrapping)
module pac #(
    parameter int BUF_AW        = 8,
    parameter int ACT_AW        = 4,
    parameter int MAX_PKT_WORDS = 96
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [133:0] in_pac_data,
    input  logic         in_pac_data_wr,
    input  logic         in_pac_valid,
    input  logic         in_pac_valid_wr,
    input  logic [10:0]  in_pac_action,
    input  logic         in_pac_action_wr,
    output logic [133:0] out_port0_data,
    output logic         out_port0_data_wr,
    input  logic         in_port0_alf,
    output logic [133:0] out_port1_data,
    output logic         out_port1_data_wr,
    input  logic         in_port1_alf,
    output logic [133:0] out_port2_data,
    output logic         out_port2_data_wr,
    input  logic         in_port2_alf,
    output logic [31:0]  out_pac_pkt_cnt,
    output logic [31:0]  out_pac_drop_cnt
);

    localparam int DEPTH = 2**BUF_AW;
    localparam int LW    = $clog2(MAX_PKT_WORDS + 1);
    localparam int DW    = 11 + LW;

    typedef enum logic [1:0] {IN_IDLE, IN_WR, IN_DROP} in_st_t;
    typedef enum logic {OUT_IDLE, OUT_SEND} out_st_t;

    logic [133:0]    r_mem  [DEPTH];
    logic [DW-1:0]   r_dmem [2**ACT_AW];

    in_st_t          r_in_st;
    logic [BUF_AW:0] r_wr_ptr, r_wr_commit, r_rd_ptr;
    logic [LW-1:0]   r_in_cnt;
    logic [10:0]     r_act;
    logic [ACT_AW:0] r_dwp, r_drp;
    logic [31:0]     r_pkt_cnt, r_drop_cnt;

    out_st_t         r_out_st;
    logic [LW-1:0]   r_len, r_rd_cnt;
    logic [2:0]      r_mask, r_out_wr;
    logic [133:0]    r_out0_data, r_out1_data, r_out2_data;

    logic [BUF_AW:0]   w_used;
    logic [BUF_AW+1:0] w_free;
    logic              w_head, w_tail, w_commit, w_act_ok, w_accept, w_ovf;
    logic              w_dfull, w_dempty, w_mem_we, w_push;
    logic [DW-1:0]     w_desc;
    logic [10:0]       w_d_act;
    logic [LW-1:0]     w_d_len;
    logic [2:0]        w_d_mask, w_alf;
    logic [BUF_AW-1:0] w_rd_addr;
    logic [133:0]      w_rd_word;
    logic              w_unused_pkttype;

    assign w_used   = r_wr_ptr - r_rd_ptr;
    assign w_free   = (BUF_AW+2)'(DEPTH) - {1'b0, w_used};
    assign w_head   = in_pac_data_wr && (in_pac_data[133:132] == 2'b01);
    assign w_tail   = in_pac_data_wr && (in_pac_data[133:132] == 2'b10);
    // A tail without its valid strobe counts as a discard.
    assign w_commit = in_pac_valid_wr && in_pac_valid;
    assign w_act_ok = (in_pac_action[10:9] == 2'b10) ||
                      ((in_pac_action[10:9] == 2'b00) && (in_pac_action[5:0] <= 6'd2));
    assign w_dfull  = (r_dwp[ACT_AW] != r_drp[ACT_AW]) &&
                      (r_dwp[ACT_AW-1:0] == r_drp[ACT_AW-1:0]);
    assign w_dempty = (r_dwp == r_drp);
    // Reserving a full max-size packet at the head keeps legal packets from overrunning.
    assign w_accept = w_head && in_pac_action_wr && w_act_ok && !w_dfull &&
                      (w_free >= (BUF_AW+2)'(MAX_PKT_WORDS));
    // Oversize or buffer-full: the next word cannot be taken.
    assign w_ovf    = (r_in_cnt >= LW'(MAX_PKT_WORDS)) || (w_used == (BUF_AW+1)'(DEPTH));

    always_comb begin
        w_mem_we = 1'b0;
        w_push   = 1'b0;
        case (r_in_st)
            IN_IDLE: w_mem_we = w_accept;
            IN_WR: begin
                w_mem_we = in_pac_data_wr && !w_ovf && (!w_tail || w_commit);
                w_push   = w_tail && !w_ovf && w_commit;
            end
            default: ;
        endcase
    end

    // Storage arrays carry no reset; pointers alone define their contents.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_wr_ptr[BUF_AW-1:0]] <= in_pac_data;
        if (w_push)   r_dmem[r_dwp[ACT_AW-1:0]]   <= {r_act, r_in_cnt + LW'(1)};
    end

    // Input FSM: accept, commit or rewind.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_st     <= IN_IDLE;
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_in_cnt    <= '0;
            r_act       <= '0;
            r_dwp       <= '0;
            r_drop_cnt  <= '0;
        end else begin
            case (r_in_st)
                IN_IDLE: begin
                    if (w_head && in_pac_action_wr) begin
                        if (w_accept) begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            r_in_cnt <= LW'(1);
                            r_act    <= in_pac_action;
                            r_in_st  <= IN_WR;
                        end else begin
                            r_in_st  <= IN_DROP;
                        end
                    end
                end
                IN_WR: begin
                    if (in_pac_data_wr) begin
                        if (w_ovf) begin
                            // wr_commit never trails rd_ptr, so rewinding is always safe.
                            r_wr_ptr <= r_wr_commit;
                            if (w_tail) begin
                                r_drop_cnt <= r_drop_cnt + 1'b1;
                                r_in_st    <= IN_IDLE;
                            end else begin
                                r_in_st    <= IN_DROP;
                            end
                        end else if (w_tail) begin
                            if (w_commit) begin
                                r_wr_ptr    <= r_wr_ptr + 1'b1;
                                r_wr_commit <= r_wr_ptr + 1'b1;
                                r_dwp       <= r_dwp + 1'b1;
                            end else begin
                                r_wr_ptr    <= r_wr_commit;
                                r_drop_cnt  <= r_drop_cnt + 1'b1;
                            end
                            r_in_st <= IN_IDLE;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            r_in_cnt <= r_in_cnt + LW'(1);
                        end
                    end
                end
                IN_DROP: begin
                    if (w_tail) begin
                        r_drop_cnt <= r_drop_cnt + 1'b1;
                        r_in_st    <= IN_IDLE;
                    end
                end
                default: r_in_st <= IN_IDLE;
            endcase
        end
    end

    assign w_desc  = r_dmem[r_drp[ACT_AW-1:0]];
    assign w_d_act = w_desc[DW-1:LW];
    assign w_d_len = w_desc[LW-1:0];
    assign w_alf   = {in_port2_alf, in_port1_alf, in_port0_alf};
    assign w_unused_pkttype = ^w_d_act[8:6];

    always_comb begin
        w_d_mask = 3'b000;
        if (w_d_act[10:9] == 2'b10) begin
            w_d_mask = 3'b111;
        end else begin
            case (w_d_act[5:0])
                6'd0:    w_d_mask = 3'b001;
                6'd1:    w_d_mask = 3'b010;
                6'd2:    w_d_mask = 3'b100;
                default: w_d_mask = 3'b000;
            endcase
        end
    end

    assign w_rd_addr = r_rd_ptr[BUF_AW-1:0] + BUF_AW'(r_rd_cnt);
    assign w_rd_word = r_mem[w_rd_addr];

    // Output FSM: strict arrival order; a blocked head descriptor blocks everything behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_st    <= OUT_IDLE;
            r_rd_ptr    <= '0;
            r_drp       <= '0;
            r_len       <= '0;
            r_rd_cnt    <= '0;
            r_mask      <= '0;
            r_out_wr    <= '0;
            r_out0_data <= '0;
            r_out1_data <= '0;
            r_out2_data <= '0;
            r_pkt_cnt   <= '0;
        end else begin
            case (r_out_st)
                OUT_IDLE: begin
                    r_out_wr    <= '0;
                    r_out0_data <= '0;
                    r_out1_data <= '0;
                    r_out2_data <= '0;
                    if (!w_dempty && ((w_d_mask & w_alf) == 3'b000)) begin
                        r_drp    <= r_drp + 1'b1;
                        r_len    <= w_d_len;
                        r_mask   <= w_d_mask;
                        r_rd_cnt <= '0;
                        r_out_st <= OUT_SEND;
                    end
                end
                OUT_SEND: begin
                    r_out_wr    <= r_mask;
                    r_out0_data <= r_mask[0] ? w_rd_word : '0;
                    r_out1_data <= r_mask[1] ? w_rd_word : '0;
                    r_out2_data <= r_mask[2] ? w_rd_word : '0;
                    r_rd_cnt    <= r_rd_cnt + LW'(1);
                    if (r_rd_cnt == r_len - LW'(1)) begin
                        r_rd_ptr  <= r_rd_ptr + (BUF_AW+1)'(r_len);
                        r_pkt_cnt <= r_pkt_cnt + 1'b1;
                        r_out_st  <= OUT_IDLE;
                    end
                end
                default: r_out_st <= OUT_IDLE;
            endcase
        end
    end

    assign out_port0_data    = r_out0_data;
    assign out_port1_data    = r_out1_data;
    assign out_port2_data    = r_out2_data;
    assign out_port0_data_wr = r_out_wr[0];
    assign out_port1_data_wr = r_out_wr[1];
    assign out_port2_data_wr = r_out_wr[2];
    assign out_pac_pkt_cnt   = r_pkt_cnt;
    assign out_pac_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_pac.sv
// Directed bench for pac: unicast, broadcast, discard, alf hold/drain, oversize drop,
// and reset in the middle of a dispatch.
module tb_pac;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [133:0] in_pac_data = '0;
    logic         in_pac_data_wr = 1'b0, in_pac_valid = 1'b0, in_pac_valid_wr = 1'b0;
    logic [10:0]  in_pac_action = '0;
    logic         in_pac_action_wr = 1'b0;
    logic [133:0] out_port0_data, out_port1_data, out_port2_data;
    logic         out_port0_data_wr, out_port1_data_wr, out_port2_data_wr;
    logic         in_port0_alf = 1'b0, in_port1_alf = 1'b0, in_port2_alf = 1'b0;
    logic [31:0]  out_pac_pkt_cnt, out_pac_drop_cnt;

    pac dut (
        .clk(clk), .rst(rst),
        .in_pac_data(in_pac_data), .in_pac_data_wr(in_pac_data_wr),
        .in_pac_valid(in_pac_valid), .in_pac_valid_wr(in_pac_valid_wr),
        .in_pac_action(in_pac_action), .in_pac_action_wr(in_pac_action_wr),
        .out_port0_data(out_port0_data), .out_port0_data_wr(out_port0_data_wr), .in_port0_alf(in_port0_alf),
        .out_port1_data(out_port1_data), .out_port1_data_wr(out_port1_data_wr), .in_port1_alf(in_port1_alf),
        .out_port2_data(out_port2_data), .out_port2_data_wr(out_port2_data_wr), .in_port2_alf(in_port2_alf),
        .out_pac_pkt_cnt(out_pac_pkt_cnt), .out_pac_drop_cnt(out_pac_drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           port;
        int           cyc;
        logic [133:0] data;
    } ev_t;

    ev_t evq[$];
    int  nz_err = 0;
    int  nchk = 0, npass = 0;
    int  tail_cyc = 0;

    // Capture every strobed word; non-strobed ports must present zero data.
    always @(negedge clk) begin
        ev_t e;
        if (out_port0_data_wr) begin e.port = 0; e.cyc = cyc; e.data = out_port0_data; evq.push_back(e); end
        else if (out_port0_data != '0) nz_err++;
        if (out_port1_data_wr) begin e.port = 1; e.cyc = cyc; e.data = out_port1_data; evq.push_back(e); end
        else if (out_port1_data != '0) nz_err++;
        if (out_port2_data_wr) begin e.port = 2; e.cyc = cyc; e.data = out_port2_data; evq.push_back(e); end
        else if (out_port2_data != '0) nz_err++;
    end

    task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [133:0] mkw(input int id, input int w, input int n);
        logic [1:0] hdr;
        hdr = (w == 0) ? 2'b01 : ((w == n - 1) ? 2'b10 : 2'b11);
        return {hdr, 4'hF, 32'(id), 32'(w), 64'hC0DE_0000_0000_0000 + 64'(id)};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pkt(input int id, input int n, input logic [10:0] act,
                            input logic vwr, input logic v);
        for (int w = 0; w < n; w++) begin
            in_pac_data      = mkw(id, w, n);
            in_pac_data_wr   = 1'b1;
            in_pac_action_wr = (w == 0);
            in_pac_action    = act;
            in_pac_valid_wr  = (w == n - 1) && vwr;
            in_pac_valid     = v;
            if (w == n - 1) tail_cyc = cyc;
            @(negedge clk);
        end
        in_pac_data = '0; in_pac_data_wr = 1'b0; in_pac_action_wr = 1'b0;
        in_pac_action = '0; in_pac_valid_wr = 1'b0; in_pac_valid = 1'b0;
    endtask

    // Pops one packet's worth of captured words; words must be consecutive cycles.
    task automatic expect_pkt(input string tag, input logic [2:0] mask, input int id,
                              input int n, input int lat_ref, output int c0);
        ev_t e;
        c0 = -1;
        for (int w = 0; w < n; w++) begin
            for (int p = 0; p < 3; p++) begin
                if (mask[p]) begin
                    if (evq.size() == 0) begin
                        chk({tag, "_missing"}, 136'(evq.size()), 136'(1));
                        return;
                    end
                    e = evq.pop_front();
                    if (c0 < 0) c0 = e.cyc;
                    chk(tag, {e.port[1:0], e.data}, {p[1:0], mkw(id, w, n)});
                    chk({tag, "_cyc"}, 136'(e.cyc), 136'(c0 + w));
                end
            end
        end
        if (lat_ref >= 0) chk({tag, "_lat"}, 136'(c0 - lat_ref), 136'(3));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int ca, cb, cx;
        idle(3);
        // Reset state
        chk("rst_wr", 136'({out_port2_data_wr, out_port1_data_wr, out_port0_data_wr}), 136'(0));
        chk("rst_data", 136'(out_port0_data | out_port1_data | out_port2_data), 136'(0));
        chk("rst_pkt", 136'(out_pac_pkt_cnt), 136'(0));
        chk("rst_drop", 136'(out_pac_drop_cnt), 136'(0));
        rst = 1'b0;
        idle(2);

        // 1: unicast to port 2, 4 words
        send_pkt(1, 4, 11'b00_001_000010, 1'b1, 1'b1);
        idle(10);
        expect_pkt("t1", 3'b100, 1, 4, tail_cyc, cx);
        chk("t1_pkt", 136'(out_pac_pkt_cnt), 136'(1));
        chk("t1_extra", 136'(evq.size()), 136'(0));

        // 2: broadcast, 2 words
        send_pkt(2, 2, 11'b10_000_000000, 1'b1, 1'b1);
        idle(10);
        expect_pkt("t2", 3'b111, 2, 2, tail_cyc, cx);
        chk("t2_pkt", 136'(out_pac_pkt_cnt), 136'(2));

        // 3: discarded packet, then a good one to port 1
        send_pkt(3, 4, 11'b00_000_000001, 1'b1, 1'b0);
        send_pkt(4, 4, 11'b00_000_000001, 1'b1, 1'b1);
        idle(12);
        chk("t3_drop", 136'(out_pac_drop_cnt), 136'(1));
        expect_pkt("t3", 3'b010, 4, 4, tail_cyc, cx);
        chk("t3_pkt", 136'(out_pac_pkt_cnt), 136'(3));

        // 4: two max-size packets held by alf, third head lacks space
        in_port0_alf = 1'b1;
        send_pkt(5, 96, 11'b00_000_000000, 1'b1, 1'b1);
        send_pkt(6, 96, 11'b00_000_000000, 1'b1, 1'b1);
        send_pkt(7, 4, 11'b00_000_000000, 1'b1, 1'b1);
        idle(10);
        chk("t4_held", 136'(evq.size()), 136'(0));
        chk("t4_drop", 136'(out_pac_drop_cnt), 136'(2));
        in_port0_alf = 1'b0;
        idle(220);
        expect_pkt("t4a", 3'b001, 5, 96, -1, ca);
        expect_pkt("t4b", 3'b001, 6, 96, -1, cb);
        chk("t4_gap", 136'(cb - (ca + 95)), 136'(2));
        chk("t4_pkt", 136'(out_pac_pkt_cnt), 136'(5));
        chk("t4_extra", 136'(evq.size()), 136'(0));

        // 5: oversize packet is dropped and rewound
        send_pkt(8, 100, 11'b00_000_000001, 1'b1, 1'b1);
        idle(10);
        chk("t5_drop", 136'(out_pac_drop_cnt), 136'(3));
        chk("t5_none", 136'(evq.size()), 136'(0));
        chk("t5_wrptr", 136'(dut.r_wr_ptr), 136'(202));
        send_pkt(9, 3, 11'b00_000_000000, 1'b1, 1'b1);
        idle(10);
        expect_pkt("t5", 3'b001, 9, 3, tail_cyc, cx);
        chk("t5_pkt", 136'(out_pac_pkt_cnt), 136'(6));

        // 6: reset during dispatch
        send_pkt(10, 8, 11'b00_000_000001, 1'b1, 1'b1);
        for (int i = 0; i < 20 && evq.size() == 0; i++) @(negedge clk);
        chk("t6_started", 136'(evq.size() > 0), 136'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("t6_wr", 136'({out_port2_data_wr, out_port1_data_wr, out_port0_data_wr}), 136'(0));
        chk("t6_data", 136'(out_port0_data | out_port1_data | out_port2_data), 136'(0));
        chk("t6_pkt", 136'(out_pac_pkt_cnt), 136'(0));
        chk("t6_drop", 136'(out_pac_drop_cnt), 136'(0));
        rst = 1'b0;
        evq.delete();
        idle(10);
        chk("t6_trunc", 136'(evq.size()), 136'(0));
        send_pkt(11, 4, 11'b00_000_000010, 1'b1, 1'b1);
        idle(10);
        expect_pkt("t6", 3'b100, 11, 4, tail_cyc, cx);
        chk("t6_pkt2", 136'(out_pac_pkt_cnt), 136'(1));
        chk("t6_drop2", 136'(out_pac_drop_cnt), 136'(0));

        chk("unmasked_zero", 136'(nz_err), 136'(0));
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
